// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencing with memory handshakes.
// Optional hung-memory watchdog is compiled in with `define MC_CTRL_TIMEOUT_EN.
module mc_ctrl #(
    parameter int          TIMEOUT = 16,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] fetch_op,
    input  logic       if_ack,
    input  logic       mem_ack,
    input  logic       Zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       RegDst,
    output logic       ExtSel,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic [2:0] state,
    output logic       halted,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010,
                           S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b101;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010,
                           OP_ANDI = 6'b010000, OP_AND = 6'b010001, OP_ORI = 6'b010010,
                           OP_OR = 6'b010011, OP_SLL = 6'b011000, OP_SLTI = 6'b011100,
                           OP_SW = 6'b100110, OP_LW = 6'b100111, OP_BEQ = 6'b110000,
                           OP_BNE = 6'b110001, OP_J = 6'b111000;

    logic [2:0] state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic       legal, rtype, use_imm, ext_zero, is_lw, is_sw, is_br, is_j, taken;
    logic [2:0] alu_op;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_q, wait_d;
`else
    // TIMEOUT only matters when the watchdog is compiled in.
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IF;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
`ifdef MC_CTRL_TIMEOUT_EN
            wait_q    <= wait_d;
`endif
        end
    end

    always_comb begin
        legal    = 1'b1;
        rtype    = 1'b0;
        use_imm  = 1'b0;
        ext_zero = 1'b0;
        alu_op   = 3'b000;
        case (op_q)
            OP_ADD:   rtype = 1'b1;
            OP_SUB:   begin rtype = 1'b1; alu_op = 3'b001; end
            OP_ADDIU: use_imm = 1'b1;
            OP_ANDI:  begin use_imm = 1'b1; ext_zero = 1'b1; alu_op = 3'b100; end
            OP_AND:   begin rtype = 1'b1; alu_op = 3'b100; end
            OP_ORI:   begin use_imm = 1'b1; ext_zero = 1'b1; alu_op = 3'b011; end
            OP_OR:    begin rtype = 1'b1; alu_op = 3'b011; end
            OP_SLL:   begin rtype = 1'b1; alu_op = 3'b010; end
            OP_SLTI:  begin use_imm = 1'b1; alu_op = 3'b110; end
            OP_SW, OP_LW: use_imm = 1'b1;
            OP_BEQ, OP_BNE: alu_op = 3'b001;
            OP_J: ;
            default:  legal = 1'b0;
        endcase
        is_lw = (op_q == OP_LW);
        is_sw = (op_q == OP_SW);
        is_br = (op_q == OP_BEQ) || (op_q == OP_BNE);
        is_j  = (op_q == OP_J);
        taken = (op_q == OP_BEQ) ? Zero : !Zero;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IF: if (if_ack) begin
                state_d = S_ID;
                op_d    = fetch_op;
            end
            S_ID: begin
                if (is_j)                   state_d = S_IF;
                else if (op_q == HALT_OP)   state_d = S_HALT;
                else if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else                    state_d = S_EXE;
            end
            S_EXE:  state_d = is_br ? S_IF : ((is_lw || is_sw) ? S_MEM : S_WB);
            S_MEM:  if (mem_ack) state_d = is_sw ? S_IF : S_WB;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
`ifdef MC_CTRL_TIMEOUT_EN
        // A same-cycle ack wins: the abort only fires on a waiting cycle.
        wait_d = wait_q;
        if ((state_q == S_IF && !if_ack) || (state_q == S_MEM && !mem_ack)) begin
            wait_d = wait_q + 8'd1;
            if (wait_q == WAIT_LAST) begin
                state_d   = S_HALT;
                timeout_d = 1'b1;
            end
        end
        if (state_d != state_q) wait_d = '0;
`endif
    end

    always_comb begin
        PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; RegWre = 1'b0;
        mRD = 1'b0; mWR = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
        DBDataSrc = 1'b0; RegDst = 1'b0; ExtSel = 1'b0;
        PCSrc = 2'b00; ALUOp = 3'b000; halted = 1'b0;
        // Strobes are forced low for the whole reset window, including IF's fetch request.
        if (Reset) begin
            if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
                ALUOp   = alu_op;
                ALUSrcA = (op_q == OP_SLL);
                ALUSrcB = use_imm;
                ExtSel  = !ext_zero;
            end
            case (state_q)
                S_IF: begin
                    InsMemRW = 1'b1;
                    IRWre    = if_ack;
                end
                S_ID: if (is_j) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b10;
                end
                S_EXE: if (is_br) begin
                    PCWre = 1'b1;
                    PCSrc = taken ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    mRD   = is_lw;
                    mWR   = is_sw;
                    PCWre = is_sw && mem_ack;
                end
                S_WB: begin
                    RegWre    = 1'b1;
                    PCWre     = 1'b1;
                    DBDataSrc = is_lw;
                    RegDst    = rtype;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: randomized instruction stream checked against an
// instruction-level model of state sequence, strobe counts and ALU controls.
module tb_mc_ctrl;

    localparam logic [5:0] HALT = 6'b111111;
`ifdef MC_CTRL_TIMEOUT_EN
    localparam int MAXD = 3;
`else
    localparam int MAXD = 5;
`endif

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] fetch_op = '0;
    logic       if_ack = 1'b0, mem_ack = 1'b0, Zero = 1'b0;
    logic       PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB;
    logic       DBDataSrc, RegDst, ExtSel, halted, illegal, timeout;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp, state;

    int total = 0;
    int bad   = 0;

    mc_ctrl #(.TIMEOUT(4), .HALT_OP(HALT)) dut (
        .CLK(CLK), .Reset(Reset), .fetch_op(fetch_op), .if_ack(if_ack),
        .mem_ack(mem_ack), .Zero(Zero), .PCWre(PCWre), .IRWre(IRWre),
        .InsMemRW(InsMemRW), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .RegDst(RegDst), .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .state(state), .halted(halted), .illegal(illegal), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    logic [21:0] all_outs;
    logic [15:0] strobes;
    assign strobes  = {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                       DBDataSrc, RegDst, ExtSel, PCSrc, ALUOp};
    assign all_outs = {strobes, state, halted, illegal, timeout};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 R-type, 1 I-type ALU, 2 lw, 3 sw, 4 branch, 5 j, 6 halt, 7 undefined
    function automatic int cls(input logic [5:0] op);
        if (op == HALT) return 6;
        case (op)
            6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b011000: return 0;
            6'b000010, 6'b010000, 6'b010010, 6'b011100:            return 1;
            6'b100111: return 2;
            6'b100110: return 3;
            6'b110000, 6'b110001: return 4;
            6'b111000: return 5;
            default:   return 7;
        endcase
    endfunction

    function automatic logic [2:0] exp_aluop(input logic [5:0] op);
        case (op)
            6'b000001, 6'b110000, 6'b110001: return 3'b001;
            6'b011000:            return 3'b010;
            6'b010010, 6'b010011: return 3'b011;
            6'b010000, 6'b010001: return 3'b100;
            6'b011100:            return 3'b110;
            default:              return 3'b000;
        endcase
    endfunction

    task automatic do_reset();
        Reset = 1'b0;
        if_ack = 1'b1; mem_ack = 1'b1;
        #1;
        chk("reset_outs", 32'(all_outs), 32'd0);
        repeat (2) @(posedge CLK);
        chk("reset_hold", 32'(all_outs), 32'd0);
        @(negedge CLK);
        if_ack = 1'b0; mem_ack = 1'b0;
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("first_fetch", 32'(InsMemRW), 32'd1);
        chk("first_state", 32'(state), 32'd0);
    endtask

    // Runs one instruction starting in its first IF cycle; acks come after the given delays.
    task automatic run_instr(input logic [5:0] op, input logic z, input int if_dly, input int mem_dly);
        int c, n_if, n_mem, n_pc, n_reg, n_ir, n_rd, n_wr;
        int tr[$];
        logic [1:0] pcsrc_seen;
        logic dbs, rdst, tk;
        c = cls(op);
        tr = {};
        for (int k = 0; k <= if_dly; k++) tr.push_back(0);
        tr.push_back(1);
        if (c <= 4) tr.push_back(2);
        if (c == 2 || c == 3) for (int k = 0; k <= mem_dly; k++) tr.push_back(3);
        if (c <= 2) tr.push_back(4);
        n_if = 0; n_mem = 0; n_pc = 0; n_reg = 0; n_ir = 0; n_rd = 0; n_wr = 0;
        pcsrc_seen = 2'b00; dbs = 1'b0; rdst = 1'b0;
        Zero = z;
        foreach (tr[i]) begin
            if (InsMemRW) begin
                if_ack = (n_if == if_dly);
                n_if++;
                fetch_op = if_ack ? op : 6'($urandom);
            end else begin
                if_ack = 1'($urandom);
                fetch_op = 6'($urandom);
            end
            if (mRD || mWR) begin
                mem_ack = (n_mem == mem_dly);
                n_mem++;
            end else begin
                mem_ack = 1'($urandom);
            end
            #4;
            chk("state", 32'(state), 32'(tr[i]));
            if (tr[i] == 2) begin
                chk("alu_op", 32'(ALUOp), 32'(exp_aluop(op)));
                chk("alu_src_a", 32'(ALUSrcA), 32'(op == 6'b011000));
                chk("alu_src_b", 32'(ALUSrcB), 32'(c == 1 || c == 2 || c == 3));
                chk("ext_sel", 32'(ExtSel), 32'(op != 6'b010000 && op != 6'b010010));
            end
            if (PCWre) begin n_pc++; pcsrc_seen = PCSrc; end
            if (RegWre) begin n_reg++; dbs = DBDataSrc; rdst = RegDst; end
            n_ir += int'(IRWre);
            n_rd += int'(mRD);
            n_wr += int'(mWR);
            @(posedge CLK); #1;
        end
        tk = (op == 6'b110000) ? z : !z;
        chk("end_state", 32'(state), (c >= 6) ? 32'd5 : 32'd0);
        chk("halted", 32'(halted), 32'(c >= 6));
        chk("illegal", 32'(illegal), 32'(c == 7));
        chk("fetch_cycles", 32'(n_if), 32'(if_dly + 1));
        chk("irwre_pulses", 32'(n_ir), 32'd1);
        chk("pcwre_pulses", 32'(n_pc), 32'(c <= 5));
        chk("pcsrc", 32'(pcsrc_seen), (c == 5) ? 32'd2 : ((c == 4 && tk) ? 32'd1 : 32'd0));
        chk("regwre_pulses", 32'(n_reg), 32'(c <= 2));
        chk("dbdatasrc", 32'(dbs), 32'(c == 2));
        chk("regdst", 32'(rdst), 32'(c == 0));
        chk("mrd_cycles", 32'(n_rd), (c == 2) ? 32'(mem_dly + 1) : 32'd0);
        chk("mwr_cycles", 32'(n_wr), (c == 3) ? 32'(mem_dly + 1) : 32'd0);
    endtask

    logic [5:0] ops [14] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                             6'b010010, 6'b010011, 6'b011000, 6'b011100, 6'b100110,
                             6'b100111, 6'b110000, 6'b110001, 6'b111000};

    initial begin
        int n_w;
        do_reset();

        // Directed: lw with a late data ack, branches both ways, jump.
        run_instr(6'b100111, 1'b0, 0, 3);
        run_instr(6'b110000, 1'b1, 0, 0);
        run_instr(6'b110000, 1'b0, 0, 0);
        run_instr(6'b110001, 1'b0, 1, 0);
        run_instr(6'b110001, 1'b1, 0, 0);
        run_instr(6'b111000, 1'b0, 0, 0);

        for (int k = 0; k < 40; k++)
            run_instr(ops[$urandom_range(0, 13)], 1'($urandom),
                      $urandom_range(0, MAXD), $urandom_range(0, MAXD));

`ifdef MC_CTRL_TIMEOUT_EN
        // sw whose data ack never arrives: watchdog aborts after four waiting cycles.
        if_ack = 1'b1; mem_ack = 1'b0; fetch_op = 6'b100110;
        #4; @(posedge CLK); #1;
        if_ack = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_w = 0;
        for (int k = 0; k < 8; k++) begin
            #4;
            n_w += int'(mWR);
            @(posedge CLK); #1;
        end
        chk("to_mwr_cycles", 32'(n_w), 32'd4);
        chk("to_state", 32'(state), 32'd5);
        chk("to_flag", 32'(timeout), 32'd1);
        do_reset();
        chk("to_cleared", 32'(timeout), 32'd0);
        run_instr(6'b100110, 1'b0, 0, 3);
        chk("to_ack_last", 32'(timeout), 32'd0);
        run_instr(6'b000000, 1'b0, 3, 0);
        chk("to_if_ack_last", 32'(timeout), 32'd0);
`else
        n_w = 0;
        run_instr(6'b100110, 1'b0, 0, 25);
        chk("no_watchdog", 32'(timeout), 32'd0);
`endif

        // Undefined opcode halts and stays halted regardless of acks.
        run_instr(6'b101010, 1'b0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            if_ack = 1'b1; mem_ack = 1'b1; fetch_op = 6'($urandom);
            #4;
            chk("halt_state", 32'(state), 32'd5);
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_strobes", 32'(strobes), 32'd0);
            @(posedge CLK); #1;
        end
        do_reset();
        chk("illegal_cleared", 32'(illegal), 32'd0);
        run_instr(HALT, 1'b0, 1, 0);
        do_reset();

        // Reset asserted while sw waits in MEM.
        if_ack = 1'b1; mem_ack = 1'b0; fetch_op = 6'b100110;
        #4; @(posedge CLK); #1;
        if_ack = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("mem_mwr", 32'(mWR), 32'd1);
        chk("mem_state", 32'(state), 32'd3);
        #1;
        Reset = 1'b0;
        #1;
        chk("rst_mwr_drop", 32'(mWR), 32'd0);
        chk("rst_outs", 32'(all_outs), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            chk("post_state", 32'(state), 32'd0);
            chk("post_mwr", 32'(mWR), 32'd0);
            chk("post_flags", 32'({illegal, timeout, halted}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
